// File: rtl/proc_pkg.sv
// Definitions shared by the pipeline-register stages: default datapath widths
// and the memory-stage access state.
package proc_pkg;

  localparam int unsigned PROC_DATA_WIDTH_DEF        = 16;
  localparam int unsigned PROC_REGFILE_LOG2_DEEP_DEF = 5;
  localparam int unsigned MEM_TIMEOUT_CYCLES_DEF     = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // A request carrying both read and write enables is treated as a load.
  function automatic logic mem_is_store(input logic rd_en, input logic wr_en);
    return wr_en & ~rd_en;
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: drives a req/ack data-memory port,
// stalls upstream while an access is outstanding, aborts on timeout.
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int unsigned PROC_DATA_WIDTH        = PROC_DATA_WIDTH_DEF,
  parameter int unsigned PROC_REGFILE_LOG2_DEEP = PROC_REGFILE_LOG2_DEEP_DEF,
  parameter int unsigned TIMEOUT_CYCLES         = MEM_TIMEOUT_CYCLES_DEF
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              reg_write_en_i,
  input  logic                              mem_write_en_i,
  input  logic                              mem_read_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  output logic                              stall_o,
  output logic                              dmem_req_o,
  output logic                              dmem_we_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_wdata_o,
  input  logic                              dmem_ack_i,
  input  logic [PROC_DATA_WIDTH-1:0]        dmem_rdata_i,
  output logic                              reg_write_en_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        wb_data_o,
  output logic                              err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e                        state_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              rwe_lat_q;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] waddr_lat_q;
  logic                              m2r_lat_q;
  logic                              req_q;
  logic                              we_q;
  logic [PROC_DATA_WIDTH-1:0]        addr_q;
  logic [PROC_DATA_WIDTH-1:0]        wdata_q;
  logic                              wb_we_q;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_addr_q;
  logic [PROC_DATA_WIDTH-1:0]        wb_data_q;
  logic                              err_q;

  logic                       mem_op;
  logic                       in_idle;
  logic                       in_access;
  logic                       timeout;
  logic [PROC_DATA_WIDTH-1:0] ack_data_d;

  assign mem_op    = mem_read_en_i | mem_write_en_i;
  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  // Ack in the final counted cycle still completes the access normally.
  assign timeout   = in_access & ~dmem_ack_i & (cnt_q == CNT_LAST);
  assign stall_o   = (in_idle & mem_op) | (in_access & ~dmem_ack_i & ~timeout);

  // The address register doubles as the latched ALU result.
  assign ack_data_d = m2r_lat_q ? dmem_rdata_i : addr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rwe_lat_q   <= 1'b0;
      waddr_lat_q <= '0;
      m2r_lat_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q     <= ACCESS;
            cnt_q       <= '0;
            req_q       <= 1'b1;
            we_q        <= mem_is_store(mem_read_en_i, mem_write_en_i);
            addr_q      <= alu_i;
            wdata_q     <= reg_data2_i;
            rwe_lat_q   <= reg_write_en_i;
            waddr_lat_q <= reg_write_addr_i;
            m2r_lat_q   <= mem_to_reg_i;
            wb_we_q     <= 1'b0;
          end else begin
            wb_we_q     <= reg_write_en_i;
            wb_addr_q   <= reg_write_addr_i;
            wb_data_q   <= alu_i;
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            wb_we_q   <= rwe_lat_q;
            wb_addr_q <= waddr_lat_q;
            wb_data_q <= ack_data_d;
          end else if (timeout) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            wb_we_q   <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            wb_we_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req_o       = req_q;
  assign dmem_we_o        = we_q;
  assign dmem_addr_o      = addr_q;
  assign dmem_wdata_o     = wdata_q;
  assign reg_write_en_o   = wb_we_q;
  assign reg_write_addr_o = wb_addr_q;
  assign wb_data_o        = wb_data_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// instruction streams compared against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          reg_write_en_i, mem_write_en_i, mem_read_en_i, mem_to_reg_i;
  logic [DW-1:0] alu_i, reg_data2_i;
  logic [AW-1:0] reg_write_addr_i;
  logic          stall_o, dmem_req_o, dmem_we_o;
  logic [DW-1:0] dmem_addr_o, dmem_wdata_o;
  logic          dmem_ack_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          reg_write_en_o;
  logic [AW-1:0] reg_write_addr_o;
  logic [DW-1:0] wb_data_o;
  logic          err_o;

  mem_wb_stage #(
    .PROC_DATA_WIDTH(DW), .PROC_REGFILE_LOG2_DEEP(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .reg_write_en_i(reg_write_en_i), .mem_write_en_i(mem_write_en_i),
    .mem_read_en_i(mem_read_en_i), .mem_to_reg_i(mem_to_reg_i),
    .alu_i(alu_i), .reg_data2_i(reg_data2_i), .reg_write_addr_i(reg_write_addr_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .reg_write_en_o(reg_write_en_o), .reg_write_addr_o(reg_write_addr_o),
    .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_err = 1'b0;

  // Observations gathered while one instruction passes through the stage.
  int            o_stall, o_access, o_lat;
  bit            o_unstable, o_bubble_bad, o_overrun;
  logic          o_dwe;
  logic [DW-1:0] o_daddr, o_dwdata;
  logic          o_rwe, o_err;
  logic [AW-1:0] o_rwa;
  logic [DW-1:0] o_wb;

  // Reference model: what one instruction should produce, from its
  // operands and the memory's ack delay k (1..T acks, 0 = never acks).
  typedef struct {
    bit            mem;
    bit            ok;
    int            stall;
    int            access;
    int            lat;
    logic          rwe;
    logic [DW-1:0] wb;
    logic          dwe;
  } exp_t;

  function automatic exp_t model(input logic we, mw, mr, m2r,
                                 input logic [DW-1:0] alu, input int k,
                                 input logic [DW-1:0] rd);
    exp_t e;
    e.mem    = mw | mr;
    e.ok     = !e.mem || (k >= 1 && k <= T);
    e.access = !e.mem ? 0 : (e.ok ? k : T);
    e.stall  = e.access;
    e.lat    = e.access + 1;
    e.rwe    = e.ok ? we : 1'b0;
    e.wb     = (e.mem && m2r) ? rd : alu;
    e.dwe    = mw & ~mr;
    return e;
  endfunction

  task automatic idle_inputs();
    reg_write_en_i = 0; mem_write_en_i = 0; mem_read_en_i = 0; mem_to_reg_i = 0;
    dmem_ack_i = 0;
  endtask

  // Presents one instruction at the current negedge and follows it until the
  // memory request is gone; upstream operands are scrambled while stalled.
  task automatic run_op(input logic we, mw, mr, m2r, input logic [DW-1:0] alu, d2,
                        input logic [AW-1:0] wa, input int k, input logic [DW-1:0] rd);
    int c, c0;
    o_stall = 0; o_access = 0; o_unstable = 0; o_bubble_bad = 0; o_overrun = 0;
    c0 = cyc;
    reg_write_en_i = we; mem_write_en_i = mw; mem_read_en_i = mr; mem_to_reg_i = m2r;
    alu_i = alu; reg_data2_i = d2; reg_write_addr_i = wa;
    dmem_ack_i = 0; dmem_rdata_i = DW'($urandom);
    #1 if (stall_o) o_stall++;
    @(negedge clk);
    c = 1;
    while (dmem_req_o === 1'b1) begin
      if (c == 1) begin
        o_dwe = dmem_we_o; o_daddr = dmem_addr_o; o_dwdata = dmem_wdata_o;
      end else if (dmem_we_o !== o_dwe || dmem_addr_o !== o_daddr || dmem_wdata_o !== o_dwdata)
        o_unstable = 1;
      if (reg_write_en_o !== 1'b0) o_bubble_bad = 1;
      o_access++;
      alu_i = DW'($urandom); reg_data2_i = DW'($urandom); reg_write_addr_i = AW'($urandom);
      dmem_ack_i   = (c == k);
      dmem_rdata_i = (c == k) ? rd : DW'($urandom);
      #1 if (stall_o) o_stall++;
      @(negedge clk);
      c++;
      if (c > 2 * T + 4) begin o_overrun = 1; break; end
    end
    idle_inputs();
    o_lat = cyc - c0;
    o_rwe = reg_write_en_o; o_rwa = reg_write_addr_o; o_wb = wb_data_o; o_err = err_o;
  endtask

  task automatic test_reset();
    idle_inputs();
    alu_i = '0; reg_data2_i = '0; reg_write_addr_i = '0; dmem_rdata_i = '0;
    rst_ni = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, reg_write_en_o,
         reg_write_addr_o, wb_data_o, err_o, stall_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rwe=%b rwa=%h wb=%h err=%b stall=%b, want all 0",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, reg_write_en_o,
               reg_write_addr_o, wb_data_o, err_o, stall_o);
    end
    rst_ni = 1;
    model_err = 0;
    @(negedge clk);
  endtask

  task automatic test_alu_op();
    run_op(1, 0, 0, 0, 16'h1234, DW'($urandom), 5'd3, 0, '0);
    n_cmp++;
    if (o_rwe !== 1'b1 || o_rwa !== 5'd3 || o_wb !== 16'h1234) begin
      n_fail++;
      $display("FAIL alu_wb: got rwe=%b rwa=%0d wb=%h, want 1/3/1234", o_rwe, o_rwa, o_wb);
    end
    n_cmp++;
    if (o_stall !== 0 || o_lat !== 1 || o_access !== 0) begin
      n_fail++;
      $display("FAIL alu_timing: got stall=%0d lat=%0d access=%0d, want 0/1/0", o_stall, o_lat, o_access);
    end
  endtask

  task automatic test_load();
    run_op(1, 0, 1, 1, 16'h0040, DW'($urandom), 5'd7, 3, 16'hBEEF);
    n_cmp++;
    if (o_daddr !== 16'h0040 || o_dwe !== 1'b0 || o_unstable) begin
      n_fail++;
      $display("FAIL load_req: got addr=%h we=%b unstable=%b, want 0040/0/0", o_daddr, o_dwe, o_unstable);
    end
    n_cmp++;
    if (o_stall !== 3 || o_lat !== 4) begin
      n_fail++;
      $display("FAIL load_timing: got stall=%0d lat=%0d, want 3/4", o_stall, o_lat);
    end
    n_cmp++;
    if (o_rwe !== 1'b1 || o_rwa !== 5'd7 || o_wb !== 16'hBEEF || o_bubble_bad) begin
      n_fail++;
      $display("FAIL load_wb: got rwe=%b rwa=%0d wb=%h bubble_bad=%b, want 1/7/beef/0",
               o_rwe, o_rwa, o_wb, o_bubble_bad);
    end
  endtask

  task automatic test_store();
    run_op(0, 1, 0, 0, 16'h0010, 16'hA5A5, 5'd9, 1, 16'h5555);
    n_cmp++;
    if (o_dwe !== 1'b1 || o_dwdata !== 16'hA5A5 || o_daddr !== 16'h0010) begin
      n_fail++;
      $display("FAIL store_req: got we=%b wdata=%h addr=%h, want 1/a5a5/0010", o_dwe, o_dwdata, o_daddr);
    end
    n_cmp++;
    if (o_rwe !== 1'b0 || o_stall !== 1 || o_access !== 1) begin
      n_fail++;
      $display("FAIL store_wb: got rwe=%b stall=%0d access=%0d, want 0/1/1", o_rwe, o_stall, o_access);
    end
  endtask

  task automatic test_timeout();
    run_op(1, 0, 1, 1, 16'h0200, DW'($urandom), 5'd4, 0, '0);
    model_err = 1;
    n_cmp++;
    if (o_access !== T || o_stall !== T || o_overrun) begin
      n_fail++;
      $display("FAIL timeout_timing: got access=%0d stall=%0d overrun=%b, want %0d/%0d/0",
               o_access, o_stall, o_overrun, T, T);
    end
    n_cmp++;
    if (o_err !== 1'b1 || o_rwe !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b rwe=%b, want 1/0", o_err, o_rwe);
    end
    run_op(1, 0, 0, 0, 16'h0ABC, '0, 5'd12, 0, '0);
    n_cmp++;
    if (o_rwe !== 1'b1 || o_rwa !== 5'd12 || o_wb !== 16'h0ABC || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL after_timeout: got rwe=%b rwa=%0d wb=%h err=%b, want 1/12/0abc/1",
               o_rwe, o_rwa, o_wb, o_err);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [DW-1:0] late;
    reg_write_en_i = 1; mem_read_en_i = 1; mem_to_reg_i = 1;
    alu_i = 16'h0300; reg_write_addr_i = 5'd5;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (dmem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got req=%b, want 1", dmem_req_o);
    end
    rst_ni = 0;
    idle_inputs();
    @(negedge clk);
    model_err = 0;
    n_cmp++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, reg_write_en_o,
         reg_write_addr_o, wb_data_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%b we=%b addr=%h wdata=%h rwe=%b rwa=%h wb=%h err=%b, want all 0",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, reg_write_en_o,
               reg_write_addr_o, wb_data_o, err_o);
    end
    rst_ni = 1;
    late = 16'hDEAD;
    alu_i = 16'h7777; reg_write_addr_i = 5'd2;
    dmem_ack_i = 1; dmem_rdata_i = late;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stall: got stall=%b, want 0", stall_o);
    end
    @(negedge clk);
    dmem_ack_i = 0;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || reg_write_en_o !== 1'b0 || wb_data_o !== 16'h7777) begin
      n_fail++;
      $display("FAIL rstmid_late_ack: got req=%b rwe=%b wb=%h, want 0/0/7777",
               dmem_req_o, reg_write_en_o, wb_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [DW-1:0] r1, r2;
    r1 = DW'($urandom); r2 = ~r1;
    c1 = cyc;
    run_op(1, 0, 1, 1, 16'h0100, '0, 5'd10, 1, r1);
    c1 = c1 + o_lat;
    n_cmp++;
    if (o_rwe !== 1'b1 || o_rwa !== 5'd10 || o_wb !== r1) begin
      n_fail++;
      $display("FAIL b2b_first: got rwe=%b rwa=%0d wb=%h, want 1/10/%h", o_rwe, o_rwa, o_wb, r1);
    end
    c2 = cyc;
    run_op(1, 0, 1, 1, 16'h0102, '0, 5'd11, 1, r2);
    c2 = c2 + o_lat;
    n_cmp++;
    if (o_rwe !== 1'b1 || o_rwa !== 5'd11 || o_wb !== r2 || (c2 - c1) !== 2) begin
      n_fail++;
      $display("FAIL b2b_second: got rwe=%b rwa=%0d wb=%h spacing=%0d, want 1/11/%h/2",
               o_rwe, o_rwa, o_wb, c2 - c1, r2);
    end
  endtask

  task automatic test_random(input int n_ops);
    logic we, mw, mr, m2r;
    logic [DW-1:0] alu, d2, rd;
    logic [AW-1:0] wa;
    int k;
    exp_t e;
    for (int i = 0; i < n_ops; i++) begin
      we = 1'($urandom); m2r = 1'($urandom);
      mw = ($urandom_range(0, 9) < 3); mr = ($urandom_range(0, 9) < 4);
      alu = DW'($urandom); d2 = DW'($urandom); wa = AW'($urandom); rd = DW'($urandom);
      k = $urandom_range(0, T + 1);
      if (k > T) k = $urandom_range(1, 2);
      e = model(we, mw, mr, m2r, alu, k, rd);
      run_op(we, mw, mr, m2r, alu, d2, wa, k, rd);
      if (!e.ok) model_err = 1;
      n_cmp++;
      if (o_stall !== e.stall || o_access !== e.access || o_lat !== e.lat || o_overrun) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: got stall=%0d access=%0d lat=%0d, want %0d/%0d/%0d (k=%0d)",
                 i, o_stall, o_access, o_lat, e.stall, e.access, e.lat, k);
      end
      n_cmp++;
      if (o_rwe !== e.rwe || (e.ok && (o_rwa !== wa || o_wb !== e.wb))) begin
        n_fail++;
        $display("FAIL rnd_wb[%0d]: got rwe=%b rwa=%0d wb=%h, want %b/%0d/%h (mem=%0d ok=%0d)",
                 i, o_rwe, o_rwa, o_wb, e.rwe, wa, e.wb, e.mem, e.ok);
      end
      if (e.mem) begin
        n_cmp++;
        if (o_dwe !== e.dwe || o_daddr !== alu || o_dwdata !== d2 || o_unstable || o_bubble_bad) begin
          n_fail++;
          $display("FAIL rnd_req[%0d]: got we=%b addr=%h wdata=%h unstable=%b bubble_bad=%b, want %b/%h/%h/0/0",
                   i, o_dwe, o_daddr, o_dwdata, o_unstable, o_bubble_bad, e.dwe, alu, d2);
        end
      end
      n_cmp++;
      if (o_err !== model_err) begin
        n_fail++;
        $display("FAIL rnd_err[%0d]: got err=%b, want %b", i, o_err, model_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    alu_i = '0; reg_data2_i = '0; reg_write_addr_i = '0; dmem_rdata_i = '0;
    @(negedge clk);
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random(60);
    test_reset();
    test_random(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
